// File: rtl/dc_motor.sv
// Brushed DC motor PWM driver: 3-bit switch code -> PWM drive (pdcm) + direction (dir).
// Define DEADTIME_EN to hold the bridge off for DEADTIME clocks around every direction reversal.
module dc_motor #(
  parameter logic [11:0] PWM_OFF  = 12'hAF0,
  parameter logic [11:0] PWM_25   = 12'hCF0,
  parameter logic [11:0] PWM_50   = 12'h8F0,
  parameter logic [11:0] PWM_75   = 12'h6F0,
  parameter int unsigned DEADTIME = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] psw,
  output logic       pdcm,
  output logic       dir
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  psw_q_reg;
  logic [11:0] cnt_reg, cnt_next;
  logic [11:0] duty_reg, duty_next;
  logic        dir_reg, dir_next;
  logic        pdcm_reg, pdcm_next;

`ifdef DEADTIME_EN
  localparam logic [7:0] DEAD_LAST = 8'(DEADTIME - 1);
  logic [7:0] dead_cnt_reg, dead_cnt_next;
`else
  logic unused_deadtime;
  assign unused_deadtime = ^DEADTIME;
`endif

  // Constant decode tables indexed by the registered switch code.
  logic [11:0] code_duty [8];
  logic [7:0]  code_rev;

  for (genvar gi = 0; gi < 8; gi++) begin : g_decode
    assign code_duty[gi] = (gi == 0)       ? 12'd0  :
                           (gi == 7)       ? PWM_OFF :
                           ((gi % 3) == 1) ? PWM_25 :
                           ((gi % 3) == 2) ? PWM_50 : PWM_75;
    assign code_rev[gi]  = (gi >= 4);
  end

  logic        req_on;
  logic        req_dir;
  logic [11:0] req_duty;

  assign req_on   = |psw_q_reg;
  assign req_dir  = code_rev[psw_q_reg];
  assign req_duty = code_duty[psw_q_reg];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 12'd1;
    duty_next  = duty_reg;
    dir_next   = dir_reg;
    pdcm_next  = 1'b0;
`ifdef DEADTIME_EN
    dead_cnt_next = dead_cnt_reg;
`endif
    case (state_reg)
      ST_OFF: begin
        if (req_on) begin
          if (req_dir == dir_reg) begin
            duty_next  = req_duty;
            cnt_next   = 12'd0;
            state_next = ST_RUN;
          end else begin
`ifdef DEADTIME_EN
            dead_cnt_next = 8'd0;
            state_next    = ST_DEAD;
`else
            dir_next   = req_dir;
            duty_next  = req_duty;
            cnt_next   = 12'd0;
            state_next = ST_RUN;
`endif
          end
        end
      end
      ST_RUN: begin
        pdcm_next = (cnt_reg < duty_reg);
        if (!req_on) begin
          state_next = ST_OFF;
          duty_next  = 12'd0;
        end else if (req_dir != dir_reg) begin
          // Reversal: the bridge is switched off on this very edge.
          pdcm_next = 1'b0;
`ifdef DEADTIME_EN
          dead_cnt_next = 8'd0;
          state_next    = ST_DEAD;
`else
          dir_next  = req_dir;
          duty_next = req_duty;
          cnt_next  = 12'd0;
`endif
        end else if (cnt_reg == 12'hFFF) begin
          // Threshold changes only at the frame boundary so no runt pulse appears.
          duty_next = req_duty;
        end
      end
`ifdef DEADTIME_EN
      ST_DEAD: begin
        if (!req_on) begin
          state_next = ST_OFF;
          duty_next  = 12'd0;
        end else if (dead_cnt_reg == DEAD_LAST) begin
          dir_next   = req_dir;
          duty_next  = req_duty;
          cnt_next   = 12'd0;
          state_next = ST_RUN;
        end else begin
          dead_cnt_next = dead_cnt_reg + 8'd1;
        end
      end
`endif
      default: begin
        state_next = ST_OFF;
        duty_next  = 12'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_OFF;
      psw_q_reg <= 3'b000;
      cnt_reg   <= 12'd0;
      duty_reg  <= 12'd0;
      dir_reg   <= 1'b0;
      pdcm_reg  <= 1'b0;
`ifdef DEADTIME_EN
      dead_cnt_reg <= 8'd0;
`endif
    end else begin
      state_reg <= state_next;
      psw_q_reg <= psw;
      cnt_reg   <= cnt_next;
      duty_reg  <= duty_next;
      dir_reg   <= dir_next;
      pdcm_reg  <= pdcm_next;
`ifdef DEADTIME_EN
      dead_cnt_reg <= dead_cnt_next;
`endif
    end
  end

  assign pdcm = pdcm_reg;
  assign dir  = dir_reg;

endmodule

// File: tb/tb_dc_motor.sv
// Bench for dc_motor: directed scenarios plus random switch sequences against a timeline model.
// Honours DEADTIME_EN the same way as the design.
module tb_dc_motor;
  localparam int DT    = 16;
  localparam int FRAME = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] psw = 3'b000;
  logic       pdcm;
  logic       dir;

  int vectors     = 0;
  int miscompares = 0;

  dc_motor dut (
    .clk (clk),
    .rst (rst),
    .psw (psw),
    .pdcm(pdcm),
    .dir (dir)
  );

  always #5 clk = ~clk;

  // Reference model: motor driving / waiting out a reversal / idle, with the PWM
  // phase derived from the edge index at which the current frame began.
  int         cyc     = 0;
  logic [2:0] m_q     = 3'b000;
  bit         m_drive = 1'b0;
  int         m_wait  = 0;
  bit         m_dir   = 1'b0;
  int         m_duty  = 0;
  int         m_t0    = 0;
  bit         m_pdcm  = 1'b0;

  function automatic int thr(input logic [2:0] c);
    case (c)
      3'd0:       return 0;
      3'd1, 3'd4: return 'hCF0;
      3'd2, 3'd5: return 'h8F0;
      3'd3, 3'd6: return 'h6F0;
      default:    return 'hAF0;
    endcase
  endfunction

  task automatic start_drive();
    m_dir   = m_q[2];
    m_duty  = thr(m_q);
    m_t0    = cyc + 1;
    m_drive = 1'b1;
  endtask

  task automatic model_edge();
    bit p;
    bit nxt;
    int phase;
    cyc++;
    if (rst) begin
      m_q = 3'b000; m_drive = 0; m_wait = 0; m_dir = 0; m_duty = 0; m_pdcm = 0;
      return;
    end
    nxt   = 1'b0;
    phase = m_drive ? (cyc - m_t0) % FRAME : 0;
    p     = m_drive && (phase < m_duty);
    if (m_drive) begin
      if (m_q == 3'b000) begin
        nxt     = p;
        m_drive = 1'b0;
      end else if (m_q[2] != m_dir) begin
`ifdef DEADTIME_EN
        m_drive = 1'b0;
        m_wait  = DT;
`else
        start_drive();
`endif
      end else begin
        nxt = p;
        if (phase == FRAME - 1) m_duty = thr(m_q);
      end
    end else if (m_wait > 0) begin
      if (m_q == 3'b000) m_wait = 0;
      else begin
        m_wait--;
        if (m_wait == 0) start_drive();
      end
    end else if (m_q != 3'b000) begin
`ifdef DEADTIME_EN
      if (m_q[2] != m_dir) m_wait = DT;
      else start_drive();
`else
      start_drive();
`endif
    end
    m_pdcm = nxt;
    m_q    = psw;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pdcm_model", int'(pdcm), int'(m_pdcm));
    check("dir_model", int'(dir), int'(m_dir));
  endtask

  task automatic run_code(input logic [2:0] code, input int n, output int highs);
    psw   = code;
    highs = 0;
    repeat (n) begin
      step();
      if (pdcm === 1'b1) highs++;
    end
  endtask

  task automatic do_reset(input logic [2:0] code, input int n);
    rst = 1'b1;
    psw = code;
    repeat (n) step();
    rst = 1'b0;
  endtask

  int h, h2, h3;

  initial begin
    // Reset with a live code present, then first frame of 011.
    do_reset(3'b011, 2);
    check("reset_pdcm", int'(pdcm), 0);
    check("reset_dir", int'(dir), 0);
    run_code(3'b011, 2, h);
    check("rise_latency_low", h, 0);
    run_code(3'b011, FRAME, h);
    check("frame_high_011", h, 1776);

    // Off mid-frame.
    do_reset(3'b000, 2);
    run_code(3'b001, 1000, h);
    check("pre_off_pdcm", int'(pdcm), 1);
    run_code(3'b000, 2, h);
    run_code(3'b000, 100, h);
    check("off_stays_low", h, 0);
    check("off_dir", int'(dir), 0);

    // Duty change at cnt=100 takes effect at the next frame.
    do_reset(3'b000, 2);
    run_code(3'b001, 102, h);
    run_code(3'b010, FRAME - 100, h2);
    check("frame_keep_3312", h + h2, 3312);
    run_code(3'b010, FRAME, h);
    check("frame_next_2288", h, 2288);

`ifdef DEADTIME_EN
    // Reversal 010 -> 101 through the dead interval.
    run_code(3'b101, 1, h);
    run_code(3'b101, DT, h);
    check("dead_low", h, 0);
    check("dead_dir_held", int'(dir), 0);
    run_code(3'b101, 1, h);
    check("rev_dir", int'(dir), 1);
    check("rev_pdcm_low", int'(pdcm), 0);
    run_code(3'b101, FRAME, h);
    check("rev_frame_2288", h, 2288);
    do_reset(3'b000, 2);
    run_code(3'b111, DT + 2, h);
`else
    // Reversal 001 -> 100 without a dead interval.
    do_reset(3'b000, 2);
    run_code(3'b001, 500, h);
    run_code(3'b100, 1, h);
    run_code(3'b100, 1, h);
    check("rev_dir", int'(dir), 1);
    check("rev_pdcm_low", int'(pdcm), 0);
    run_code(3'b100, FRAME, h);
    check("rev_frame_3312", h, 3312);
    do_reset(3'b000, 2);
    run_code(3'b111, 2, h);
`endif

    // Code 111 from reset: reverse crawl.
    check("crawl_pre_low", h, 0);
    check("crawl_dir", int'(dir), 1);
    run_code(3'b111, FRAME, h);
    check("crawl_frame_2800", h, 2800);

    // 111 then 000 shortly after; with a dead interval dir never flips.
    do_reset(3'b000, 1);
    run_code(3'b111, 5, h);
    run_code(3'b000, 10, h2);
    run_code(3'b000, 30, h3);
    check("abort_low", h3, 0);
`ifdef DEADTIME_EN
    check("abort_dir", int'(dir), 0);
`else
    check("abort_dir", int'(dir), 1);
`endif

    // Reset in the middle of a reversal / frame.
    run_code(3'b010, 300, h);
    run_code(3'b110, 6, h);
    do_reset(3'b110, 1);
    check("midrst_pdcm", int'(pdcm), 0);
    check("midrst_dir", int'(dir), 0);

    // Random switch sequences with occasional resets.
    repeat (60) begin
      if ($urandom_range(0, 9) == 0) do_reset(3'($urandom_range(0, 7)), 1);
      run_code(3'($urandom_range(0, 7)), int'($urandom_range(1, 300)), h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
